// File: rtl/regfile_dump_tx_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// Frame: header, then (index, little-endian data) per register, then checksum.
package regfile_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    IDX,
    DATA,
    CSUM
  } dump_state_e;

  localparam logic [7:0] DUMP_HDR = 8'hA5;

  function automatic int dump_frame_len(input int nregs, input int xlen);
    return 2 + nregs * (1 + xlen / 8);
  endfunction

  localparam int DUMP_FRAME_LEN = dump_frame_len(32, 32);

endpackage

// File: rtl/dump_csum8.sv
// 8-bit modulo-256 accumulator with synchronous clear and add-on-enable.
module dump_csum8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_byte,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (clr) begin
      sum <= 8'h00;
    end else if (add_en) begin
      sum <= sum + add_byte;
    end
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// Streams a snapshot of the architectural registers as a framed byte stream,
// halting the core for the duration so the snapshot is consistent.
module regfile_dump_tx
  import regfile_dump_tx_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_req,
  output logic            busy,
  output logic            done,
  output logic            cpu_halt,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam int NBYTES = XLEN / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW-1:0]  LAST_REG  = AW'(NREGS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  dump_state_e     state, state_nxt;
  logic [AW-1:0]   reg_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [XLEN-1:0] shreg;
  logic [7:0]      csum;
  logic            xfer, start, last_byte, last_reg, csum_add;

  assign xfer      = tx_valid & tx_ready;
  // A request coinciding with the done pulse belongs to the finished frame.
  assign start     = (state == IDLE) & dump_req & ~done;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (reg_cnt == LAST_REG);
  assign csum_add  = xfer & ((state == IDX) | (state == DATA));

  assign busy     = (state != IDLE);
  assign cpu_halt = busy;
  assign rf_raddr = reg_cnt;

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = DUMP_HDR;
        if (xfer) state_nxt = IDX;
      end
      IDX: begin
        tx_valid = 1'b1;
        tx_data  = 8'(reg_cnt);
        if (xfer) state_nxt = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = shreg[7:0];
        if (xfer && last_byte) state_nxt = last_reg ? CSUM : IDX;
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      reg_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == CSUM) & xfer;
      if (start) begin
        reg_cnt  <= '0;
        byte_cnt <= '0;
      end else if ((state == IDX) && xfer) begin
        // Capture happens as the index byte leaves; the core is halted.
        shreg    <= rf_rdata;
        byte_cnt <= '0;
      end else if ((state == DATA) && xfer) begin
        shreg    <= {8'h00, shreg[XLEN-1:8]};
        byte_cnt <= byte_cnt + BCW'(1);
        if (last_byte && !last_reg) reg_cnt <= reg_cnt + AW'(1);
      end
    end
  end

  dump_csum8 u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .add_en   (csum_add),
    .add_byte (tx_data),
    .sum      (csum)
  );

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: frame content, checksum, backpressure,
// ignored requests and mid-frame reset.
module tb_regfile_dump_tx;

  localparam int FLEN = 162;

  logic        clk, rst, dump_req, busy, done, cpu_halt, tx_valid, tx_ready;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [7:0]  tx_data;

  logic [31:0] rf [0:31];
  logic [7:0]  got  [0:199];
  logic [7:0]  expf [0:199];

  int errors = 0;
  int checks = 0;
  int nbytes, ndone, halt_bad, stab_bad, tv_bad;
  bit aborted;

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'h0 : rf[rf_raddr];

  regfile_dump_tx dut (
    .clk      (clk),
    .rst      (rst),
    .dump_req (dump_req),
    .busy     (busy),
    .done     (done),
    .cpu_halt (cpu_halt),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic build_exp();
    int p;
    logic [7:0]  sum;
    logic [31:0] v;
    expf[0] = 8'hA5;
    p = 1;
    sum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h0 : rf[i];
      expf[p] = 8'(i);
      sum = sum + 8'(i);
      p++;
      for (int k = 0; k < 4; k++) begin
        expf[p] = v[8*k +: 8];
        sum = sum + v[8*k +: 8];
        p++;
      end
    end
    expf[p] = sum;
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_len"}, nbytes, FLEN);
    for (int k = 0; k < FLEN; k++)
      chk($sformatf("%s_b%0d", tag, k), got[k], expf[k]);
  endtask

  // Runs one frame: rnd selects random tx_ready, req_at injects a request at
  // that byte count, dup_done requests again in the done cycle, rst_at resets.
  task automatic run_frame(input bit rnd, input int req_at, input bit dup_done,
                           input int rst_at);
    bit         prev_stall, req_sent;
    logic [7:0] prev_data;
    int         post;
    nbytes = 0; ndone = 0; halt_bad = 0; stab_bad = 0; tv_bad = 0;
    aborted = 0; prev_stall = 0; prev_data = 8'h00; req_sent = 0; post = 0;
    @(negedge clk);
    dump_req = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (busy !== cpu_halt) halt_bad++;
      if (done) begin
        ndone++;
        if (dup_done) dump_req = 1'b1;
      end
      if (prev_stall && tx_data !== prev_data) stab_bad++;
      if (rst_at >= 0 && nbytes == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_halt", cpu_halt, 0);
        chk("rst_done", done, 0);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        aborted = 1;
        return;
      end
      if (post > 0) begin
        if (tx_valid) tv_bad++;
        post++;
        if (post > 5) break;
      end else begin
        if (req_at >= 0 && nbytes == req_at && !req_sent) begin
          dump_req = 1'b1;
          req_sent = 1;
        end
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) begin
          got[nbytes] = tx_data;
          nbytes++;
          if (nbytes == FLEN) post = 1;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
    tx_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; dump_req = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
    #12;
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cpu_halt", cpu_halt, 0);
    chk("reset_raddr", rf_raddr, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // Incrementing pattern, no backpressure.
    build_exp();
    run_frame(0, -1, 0, -1);
    compare_frame("inc");
    chk("inc_csum", got[161], 8'hB0);
    chk("inc_done_count", ndone, 1);
    chk("inc_halt_eq_busy", halt_bad, 0);
    chk("inc_valid_after", tv_bad, 0);

    // Distinct data in x5.
    rf[5] = 32'hDEADBEEF;
    build_exp();
    run_frame(0, -1, 0, -1);
    compare_frame("x5");
    chk("x5_idx", got[26], 8'h05);
    chk("x5_b0", got[27], 8'hEF);
    chk("x5_b1", got[28], 8'hBE);
    chk("x5_b2", got[29], 8'hAD);
    chk("x5_b3", got[30], 8'hDE);
    chk("x5_csum", got[161], 8'hD4);

    // Random backpressure; same expected frame.
    run_frame(1, -1, 0, -1);
    compare_frame("rnd");
    chk("rnd_stable", stab_bad, 0);
    chk("rnd_halt_eq_busy", halt_bad, 0);
    chk("rnd_done_count", ndone, 1);

    // Requests while busy and in the done cycle are ignored.
    run_frame(0, 40, 1, -1);
    compare_frame("dup");
    chk("dup_done_count", ndone, 1);
    chk("dup_valid_after", tv_bad, 0);

    // Reset mid-frame, then a clean frame.
    run_frame(0, -1, 0, 80);
    chk("abort_flag", aborted, 1);
    run_frame(0, -1, 0, -1);
    compare_frame("post_rst");
    chk("post_rst_done", ndone, 1);

    // Writes to x0 never show up.
    rf[0] = 32'hFFFFFFFF;
    build_exp();
    run_frame(0, -1, 0, -1);
    compare_frame("x0");
    for (int k = 1; k <= 5; k++) chk($sformatf("x0_slice%0d", k), got[k], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
